// File: rtl/bgpu_tblock_dispatcher.sv
// Thread-block dispatch controller: host-programmed kernel launch, one dispatch
// request per thread block over valid/ready, completion counting and status.
module bgpu_tblock_dispatcher #(
   parameter int unsigned PcWidth   = 32,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned TgIdWidth = 32,
   parameter int unsigned CntWidth  = 28
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 reg_req_i,
   input  logic                 reg_we_i,
   input  logic [4:0]           reg_addr_i,
   input  logic [31:0]          reg_wdata_i,
   output logic                 reg_rvalid_o,
   output logic [31:0]          reg_rdata_o,
   output logic                 disp_valid_o,
   input  logic                 disp_ready_i,
   output logic [PcWidth-1:0]   disp_pc_o,
   output logic [AddrWidth-1:0] disp_dp_addr_o,
   output logic [TgIdWidth-1:0] disp_tgroup_id_o,
   output logic [CntWidth-1:0]  disp_tblock_id_o,
   input  logic                 done_i,
   output logic                 busy_o
);

   localparam int unsigned RegW = 32;

   localparam logic [1:0] StIdle     = 2'd0;
   localparam logic [1:0] StDispatch = 2'd1;
   localparam logic [1:0] StWaitDone = 2'd2;
   localparam logic [1:0] StFinished = 2'd3;

   localparam logic [2:0] IdxPc     = 3'd0;
   localparam logic [2:0] IdxDp     = 3'd1;
   localparam logic [2:0] IdxNum    = 3'd2;
   localparam logic [2:0] IdxTgid   = 3'd3;
   localparam logic [2:0] IdxCtrl   = 3'd4;

   logic [1:0]           state_q, state_d;
   logic [PcWidth-1:0]   pc_q, pc_d;
   logic [AddrWidth-1:0] dp_q, dp_d;
   logic [CntWidth-1:0]  num_q, num_d;
   logic [TgIdWidth-1:0] tgid_q, tgid_d;
   logic                 start_pending_q, start_pending_d;
   logic [CntWidth-1:0]  disp_cnt_q, disp_cnt_d;
   logic [CntWidth-1:0]  done_cnt_q, done_cnt_d;
   logic                 disp_valid_q, disp_valid_d;
   logic                 busy_q, busy_d;
   logic [CntWidth-1:0]  tblock_id_q, tblock_id_d;
   logic                 rvalid_q, rvalid_d;
   logic [RegW-1:0]      rdata_q, rdata_d;

   logic [2:0]      reg_idx;
   logic            reg_wr, reg_rd, idle_like, finished, handshake, done_inc;
   logic [RegW-1:0] status;
   logic            addr_lsb_unused;

   assign reg_idx         = reg_addr_i[4:2];
   assign addr_lsb_unused = ^reg_addr_i[1:0];

   // Register file, host response and dispatch FSM next-state logic
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      dp_d            = dp_q;
      num_d           = num_q;
      tgid_d          = tgid_q;
      start_pending_d = start_pending_q;
      disp_cnt_d      = disp_cnt_q;
      done_cnt_d      = done_cnt_q;
      rvalid_d        = reg_req_i;
      rdata_d         = '0;

      reg_wr    = reg_req_i && reg_we_i;
      reg_rd    = reg_req_i && !reg_we_i;
      idle_like = (state_q == StIdle) || (state_q == StFinished);
      finished  = (state_q == StFinished);
      handshake = disp_valid_q && disp_ready_i;
      done_inc  = done_i && busy_q && (done_cnt_q != num_q);
      status    = (RegW'(done_cnt_q) << 4) | RegW'({finished, busy_q, start_pending_q});

      if (reg_wr && idle_like) begin
         case (reg_idx)
            IdxPc:   pc_d            = PcWidth'(reg_wdata_i);
            IdxDp:   dp_d            = AddrWidth'(reg_wdata_i);
            IdxNum:  num_d           = CntWidth'(reg_wdata_i);
            IdxTgid: tgid_d          = TgIdWidth'(reg_wdata_i);
            IdxCtrl: start_pending_d = 1'b1;
            default: ;
         endcase
      end

      if (reg_rd) begin
         case (reg_idx)
            IdxPc:   rdata_d = RegW'(pc_q);
            IdxDp:   rdata_d = RegW'(dp_q);
            IdxNum:  rdata_d = RegW'(num_q);
            IdxTgid: rdata_d = RegW'(tgid_q);
            IdxCtrl: rdata_d = status;
            default: rdata_d = '0;
         endcase
      end

      done_cnt_d = done_cnt_q + CntWidth'(done_inc);

      case (state_q)
         StIdle, StFinished: begin
            if (start_pending_q) begin
               start_pending_d = 1'b0;
               disp_cnt_d      = '0;
               done_cnt_d      = '0;
               state_d         = (num_q == '0) ? StFinished : StDispatch;
            end
         end
         StDispatch: begin
            if (handshake) begin
               disp_cnt_d = disp_cnt_q + CntWidth'(1);
               // Last block: skip WAIT_DONE when every completion is already in
               if (disp_cnt_d == num_q) begin
                  state_d = (done_cnt_d == num_q) ? StFinished : StWaitDone;
               end
            end
         end
         StWaitDone: begin
            if (done_cnt_d == num_q) begin
               state_d = StFinished;
            end
         end
         default: state_d = StIdle;
      endcase

      disp_valid_d = (state_d == StDispatch);
      busy_d       = (state_d == StDispatch) || (state_d == StWaitDone);
      tblock_id_d  = disp_cnt_d;
   end

   // State and output registers, synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q         <= StIdle;
         pc_q            <= '0;
         dp_q            <= '0;
         num_q           <= '0;
         tgid_q          <= '0;
         start_pending_q <= 1'b0;
         disp_cnt_q      <= '0;
         done_cnt_q      <= '0;
         disp_valid_q    <= 1'b0;
         busy_q          <= 1'b0;
         tblock_id_q     <= '0;
         rvalid_q        <= 1'b0;
         rdata_q         <= '0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         dp_q            <= dp_d;
         num_q           <= num_d;
         tgid_q          <= tgid_d;
         start_pending_q <= start_pending_d;
         disp_cnt_q      <= disp_cnt_d;
         done_cnt_q      <= done_cnt_d;
         disp_valid_q    <= disp_valid_d;
         busy_q          <= busy_d;
         tblock_id_q     <= tblock_id_d;
         rvalid_q        <= rvalid_d;
         rdata_q         <= rdata_d;
      end
   end

   assign reg_rvalid_o     = rvalid_q;
   assign reg_rdata_o      = rdata_q;
   assign disp_valid_o     = disp_valid_q;
   assign disp_pc_o        = pc_q;
   assign disp_dp_addr_o   = dp_q;
   assign disp_tgroup_id_o = tgid_q;
   assign disp_tblock_id_o = tblock_id_q;
   assign busy_o           = busy_q;

endmodule

// File: tb/tb_bgpu_tblock_dispatcher.sv
// Directed bench for bgpu_tblock_dispatcher with a transaction-level model of
// register contents and expected dispatch order.
module tb_bgpu_tblock_dispatcher;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        reg_req_i, reg_we_i;
   logic [4:0]  reg_addr_i;
   logic [31:0] reg_wdata_i;
   logic        reg_rvalid_o;
   logic [31:0] reg_rdata_o;
   logic        disp_valid_o, disp_ready_i;
   logic [31:0] disp_pc_o, disp_dp_addr_o, disp_tgroup_id_o;
   logic [27:0] disp_tblock_id_o;
   logic        done_i, busy_o;

   always #5 clk = ~clk;

   bgpu_tblock_dispatcher dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .reg_req_i(reg_req_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
      .reg_wdata_i(reg_wdata_i), .reg_rvalid_o(reg_rvalid_o), .reg_rdata_o(reg_rdata_o),
      .disp_valid_o(disp_valid_o), .disp_ready_i(disp_ready_i),
      .disp_pc_o(disp_pc_o), .disp_dp_addr_o(disp_dp_addr_o),
      .disp_tgroup_id_o(disp_tgroup_id_o), .disp_tblock_id_o(disp_tblock_id_o),
      .done_i(done_i), .busy_o(busy_o)
   );

   int n_chk = 0;
   int n_pass = 0;

   // model of programmed configuration and run progress
   logic [31:0] m_pc, m_dp, m_tgid;
   int          m_num;
   int          m_next_id;
   int          m_valid_cycles;

   int   cyc = 0;
   int   hs_q[$];
   bit   done_auto, done_man, ready_rand, ready_man;

   bit          prev_stall;
   logic [27:0] prev_id;
   logic [31:0] prev_pc, prev_dp, prev_tg;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // per-cycle compare of the dispatch channel against the model
   always @(negedge clk) begin
      if (!rst_ni) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("valid_hold", 64'(disp_valid_o), 64'd1);
            chk("id_hold", 64'(disp_tblock_id_o), 64'(prev_id));
            chk("pc_hold", 64'(disp_pc_o), 64'(prev_pc));
            chk("dp_hold", 64'(disp_dp_addr_o), 64'(prev_dp));
            chk("tg_hold", 64'(disp_tgroup_id_o), 64'(prev_tg));
         end
         if (disp_valid_o) begin
            m_valid_cycles++;
            chk("busy_when_valid", 64'(busy_o), 64'd1);
            chk("disp_pc", 64'(disp_pc_o), 64'(m_pc));
            chk("disp_dp", 64'(disp_dp_addr_o), 64'(m_dp));
            chk("disp_tgid", 64'(disp_tgroup_id_o), 64'(m_tgid));
            chk("disp_id", 64'(disp_tblock_id_o), 64'(m_next_id));
            if (disp_ready_i) begin
               m_next_id++;
               hs_q.push_back(cyc);
               chk("id_in_range", 64'(m_next_id <= m_num), 64'd1);
            end
            prev_stall = !disp_ready_i;
            prev_id = disp_tblock_id_o;
            prev_pc = disp_pc_o;
            prev_dp = disp_dp_addr_o;
            prev_tg = disp_tgroup_id_o;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   // completion pulses (5 cycles after each handshake) and ready generation
   initial begin
      done_i = 1'b0;
      disp_ready_i = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         done_i = done_man;
         if (done_auto && hs_q.size() > 0 && hs_q[0] + 5 <= cyc) begin
            void'(hs_q.pop_front());
            done_i = 1'b1;
         end
         disp_ready_i = ready_rand ? ($urandom_range(0, 9) < 3) : ready_man;
      end
   end

   task automatic reg_acc(input logic we, input logic [4:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input string name);
      @(posedge clk); #1;
      reg_req_i = 1'b1; reg_we_i = we; reg_addr_i = a; reg_wdata_i = wd;
      @(posedge clk); #1;
      reg_req_i = 1'b0; reg_we_i = 1'b0;
      @(negedge clk);
      chk({name, "_rvalid"}, 64'(reg_rvalid_o), 64'd1);
      chk(name, 64'(reg_rdata_o), 64'(exp_rd));
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      reg_acc(1'b1, a, d, 32'h0, "wr_resp");
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
      reg_acc(1'b0, a, 32'h0, exp, name);
   endtask

   // returns at the negedge after the FSM has left the start_pending phase
   task automatic start_run();
      m_next_id = 0;
      m_valid_cycles = 0;
      wr(5'h10, 32'h1);
      @(negedge clk);
   endtask

   task automatic wait_idle(input int bound, input string name);
      int n = 0;
      while (busy_o && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(busy_o), 64'd0);
   endtask

   initial begin
      rst_ni = 1'b0;
      reg_req_i = 1'b0; reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
      done_auto = 1'b0; done_man = 1'b0; ready_rand = 1'b0; ready_man = 1'b0;
      m_pc = 0; m_dp = 0; m_tgid = 0; m_num = 0; m_next_id = 0; m_valid_cycles = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 64'(disp_valid_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_rvalid", 64'(reg_rvalid_o), 64'd0);
      chk("rst_rdata", 64'(reg_rdata_o), 64'd0);
      chk("rst_id", 64'(disp_tblock_id_o), 64'd0);
      @(posedge clk); #1 rst_ni = 1'b1;

      // configuration and readback
      wr(5'h00, 32'h0); wr(5'h04, 32'h1); wr(5'h08, 32'd24); wr(5'h0C, 32'h2);
      m_pc = 32'h0; m_dp = 32'h1; m_num = 24; m_tgid = 32'h2;
      rd(5'h00, 32'h0, "rd_pc"); rd(5'h04, 32'h1, "rd_dp");
      rd(5'h08, 32'd24, "rd_num"); rd(5'h0C, 32'h2, "rd_tgid");
      rd(5'h10, 32'h0, "rd_status_idle");
      wr(5'h14, 32'hFFFF_FFFF);
      rd(5'h14, 32'h0, "rd_unmapped");

      // full run, ready tied high
      ready_man = 1'b1; done_auto = 1'b1;
      start_run();
      wait_idle(300, "runA_timeout");
      chk("runA_handshakes", 64'(m_next_id), 64'd24);
      chk("runA_valid_cycles", 64'(m_valid_cycles), 64'd24);
      rd(5'h10, 32'h184, "runA_status");
      rd(5'h10, 32'((m_num << 4) | 4), "runA_status_model");

      // backpressure with ignored mid-run writes
      ready_rand = 1'b1;
      start_run();
      for (int i = 0; i < 500 && m_next_id < 3; i++) @(negedge clk);
      chk("runB_progress", 64'(m_next_id >= 3), 64'd1);
      wr(5'h00, 32'hDEAD_BEEF);
      wr(5'h10, 32'h1);
      rd(5'h00, 32'h0, "runB_pc_frozen");
      wait_idle(2000, "runB_timeout");
      ready_rand = 1'b0;
      chk("runB_handshakes", 64'(m_next_id), 64'd24);
      rd(5'h10, 32'h184, "runB_status");

      // zero-block launch
      wr(5'h08, 32'd0); m_num = 0;
      start_run();
      chk("zero_busy", 64'(busy_o), 64'd0);
      rd(5'h10, 32'h4, "zero_status");
      repeat (4) @(negedge clk);
      chk("zero_no_valid", 64'(m_valid_cycles), 64'd0);

      // completion coincident with the final handshake
      wr(5'h08, 32'd2); m_num = 2;
      done_auto = 1'b0; ready_man = 1'b0;
      start_run();
      @(posedge clk); #1 ready_man = 1'b1;
      @(posedge clk); #1 ready_man = 1'b0; done_man = 1'b1;
      @(posedge clk); #1 ready_man = 1'b1; done_man = 1'b1;
      @(posedge clk); #1 ready_man = 1'b0; done_man = 1'b0;
      @(negedge clk);
      chk("coinc_direct_finish", 64'(busy_o), 64'd0);
      chk("coinc_handshakes", 64'(m_next_id), 64'd2);
      rd(5'h10, 32'h24, "coinc_status");
      hs_q.delete();

      // synchronous reset while dispatching
      wr(5'h08, 32'd24); m_num = 24;
      start_run();
      chk("pre_rst_valid", 64'(disp_valid_o), 64'd1);
      @(posedge clk); #1 rst_ni = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_valid", 64'(disp_valid_o), 64'd0);
      chk("midrst_busy", 64'(busy_o), 64'd0);
      chk("midrst_id", 64'(disp_tblock_id_o), 64'd0);
      chk("midrst_dp", 64'(disp_dp_addr_o), 64'd0);
      @(posedge clk); #1 rst_ni = 1'b1;
      hs_q.delete();
      m_pc = 0; m_dp = 0; m_tgid = 0; m_num = 0;
      rd(5'h00, 32'h0, "midrst_pc"); rd(5'h04, 32'h0, "midrst_rd_dp");
      rd(5'h08, 32'h0, "midrst_num"); rd(5'h0C, 32'h0, "midrst_tgid");
      rd(5'h10, 32'h0, "midrst_status");

      // clean restart after reset
      wr(5'h00, 32'h100); wr(5'h04, 32'h200); wr(5'h08, 32'd3); wr(5'h0C, 32'h7);
      m_pc = 32'h100; m_dp = 32'h200; m_num = 3; m_tgid = 32'h7;
      ready_man = 1'b1; done_auto = 1'b1;
      start_run();
      wait_idle(200, "runE_timeout");
      chk("runE_handshakes", 64'(m_next_id), 64'd3);
      rd(5'h10, 32'h34, "runE_status");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bgpu_tblock_dispatcher.md
Name: bgpu_tblock_dispatcher

Overview:
Memory-mapped thread-block dispatch controller for the BGPU SoC. Host (JTAG/system bus) programs PC, data-pointer address, thread-block count and thread-group ID, then writes the control register to start. The block issues one dispatch request per thread block to the compute cluster over a valid/ready handshake. It counts completion pulses and reports start/running/finished state plus the finished-block count in the status register.

Parameters:
PcWidth, 32, width of kernel start PC
AddrWidth, 32, width of data-pointer address
TgIdWidth, 32, width of thread-group ID
CntWidth, 28, width of thread-block count and IDs; must be <=28 so the count fits status[31:4]

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
reg_req_i  in  1  register access request; always accepted, no stall
reg_we_i  in  1  1 = write, 0 = read
reg_addr_i  in  5  byte offset (0x00-0x10); bits[1:0] ignored
reg_wdata_i  in  32  write data
reg_rvalid_o  out  1  read/write response valid, 1 cycle after reg_req_i
reg_rdata_o  out  32  read data; 0 for writes and unmapped addresses
disp_valid_o  out  1  dispatch request valid
disp_ready_i  in  1  cluster accepts dispatch
disp_pc_o  out  PcWidth  kernel PC
disp_dp_addr_o  out  AddrWidth  data-pointer address
disp_tgroup_id_o  out  TgIdWidth  thread-group ID
disp_tblock_id_o  out  CntWidth  index of the block being dispatched
done_i  in  1  one-cycle pulse: one thread block finished
busy_o  out  1  FSM in DISPATCH or WAIT_DONE

Behaviour:
- Register map: 0x00 PC, 0x04 DP_ADDR, 0x08 NUM_TBLOCKS (low CntWidth bits), 0x0C TGROUP_ID, 0x10 CTRL/STATUS.
- STATUS read: bit0 start_pending, bit1 running (=busy_o), bit2 finished, bit3 0, [31:4] done count zero-extended.
- Write to 0x10, any data: start request. Honoured only in IDLE or FINISHED; ignored while busy.
- Writes to 0x00-0x0C while busy_o=1 are ignored. Reads always return the current register value.
- Unmapped offsets: writes ignored, reads return 0. Response arrives one cycle after the request (reg_rvalid_o=1) for reads and writes.
- FSM states: IDLE, DISPATCH, WAIT_DONE, FINISHED.
  - IDLE/FINISHED + start write: next cycle start_pending=1. The cycle after that: clear dispatch count, done count and finished; go to DISPATCH. If NUM_TBLOCKS==0, go to FINISHED instead. start_pending clears on that transition.
  - DISPATCH: disp_valid_o=1 and disp_tblock_id_o=dispatch count. PC/DP/TGID outputs come straight from the registers, which are frozen while busy. On valid&&ready, increment the dispatch count. On the handshake of block NUM_TBLOCKS-1: go to FINISHED if all done pulses have already been counted (including one in the same cycle), else go to WAIT_DONE.
  - disp_valid_o, once high, stays high with stable payload until ready (no retraction).
  - WAIT_DONE: when done count reaches NUM_TBLOCKS, including via a pulse this cycle, go to FINISHED.
  - FINISHED: finished=1; hold done count until the next start.
- done_i is counted in DISPATCH and WAIT_DONE. Pulses in IDLE/FINISHED are ignored. The done count saturates at NUM_TBLOCKS.
- Counters are CntWidth bits and do not wrap within a run, since NUM_TBLOCKS < 2^CntWidth.
- Reset (synchronous, any state, including mid-run): FSM=IDLE; all registers, counters and flags 0; disp_valid_o=0, reg_rvalid_o=0, reg_rdata_o=0, busy_o=0. All disp_* payload outputs reset to 0.

Test Plan:
- Config readback: write PC=0x0, DP=0x1, NUM=24, TGID=0x2 -> reads return the same values one cycle after each request. STATUS=0x0.
- Full run, disp_ready_i tied 1, done_i pulsed once per accepted block after 5 cycles -> 24 handshakes with tblock_id 0..23 and PC=0/DP=1/TGID=2. Final STATUS=0x184 (count 24, finished).
- Backpressure: disp_ready_i random 30% -> payload and tblock_id stable while valid&&!ready. Still exactly 24 handshakes, no gaps or duplicates in IDs.
- NUM_TBLOCKS=0 then start -> no disp_valid_o. FINISHED within 2 cycles. STATUS=0x4.
- Start write and PC write mid-run -> ignored: PC unchanged, dispatch continues. done_i coincident with the last handshake goes directly to FINISHED.
- Synchronous reset asserted mid-DISPATCH -> next edge: disp_valid_o=0, STATUS=0, all registers read 0. A new run starts cleanly from tblock_id 0.
